// File: rtl/sha256_batch_hasher.sv
// sha256_batch_hasher
//
// Second-stage SHA-256 engine. It hashes NUM_NONCES first-stage 256-bit digests
// one after another. Each digest is hashed as a single padded 512-bit block, and
// each 8-word result is written to memory as a strided word array. Word j of
// nonce n goes to output_addr + n + j*WORD_STRIDE; the address is 16 bits and
// wraps at 0xFFFF.
//
// Parameters:
//   NUM_NONCES   digests per batch (1..256)
//   WORD_STRIDE  address distance between consecutive words of one digest
//                (>= NUM_NONCES)
//
// Ports:
//   clk             clock; also forwarded as mem_clk
//   reset_n         asynchronous active-low reset
//   start           batch request, only looked at while idle
//   output_addr     base word address, captured when start is accepted
//   hin             input digests, word j of nonce n at [(n*256 + j*32) +: 32]
//   busy            high while a batch is in progress
//   done            one-cycle pulse when the batch completes
//   mem_clk         = clk
//   mem_we          write strobe
//   mem_addr        write address
//   mem_write_data  write data
//   cycle_count     (only with SHA256_BATCH_CYCLE_CNT_EN) busy cycles of the
//                   current or last batch
//
// Optional feature macro: SHA256_BATCH_CYCLE_CNT_EN
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start
// LOAD    | a..h <= IV, message window <= digest of nonce n plus padding
// COMPUTE | 64 rounds, one per cycle, rolling 16-word schedule window
// FINAL   | add IV into a..h to form H0..H7
// WRITE   | write H0..H7, then the next nonce or back to idle

module sha256_batch_hasher #(
   parameter int NUM_NONCES  = 16,
   parameter int WORD_STRIDE = NUM_NONCES
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic [15:0]             output_addr,
   input  logic [NUM_NONCES*256-1:0] hin,
   output logic                    busy,
   output logic                    done,
   output logic                    mem_clk,
   output logic                    mem_we,
   output logic [15:0]             mem_addr,
   output logic [31:0]             mem_write_data
`ifdef SHA256_BATCH_CYCLE_CNT_EN
   ,
   output logic [31:0]             cycle_count
`endif
);

   typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, FINAL, WRITE} state_t;

   localparam logic [31:0] IV [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   function automatic logic [31:0] rotr(input logic [31:0] x, input int r);
      return (x >> r) | (x << (32 - r));
   endfunction

   state_t        state, state_nxt;
   logic [7:0]    n;
   logic [5:0]    t;
   logic [15:0]   base;
   logic [31:0]   st [8];
   logic [31:0]   w [16];
   logic          done_r;

   logic          last_nonce;
   logic [31:0]   wr_sum;
   logic [31:0]   big_s0, big_s1, ch, maj, t1, t2, w_new;

   assign mem_clk    = clk;
   assign busy       = (state != IDLE);
   assign done       = done_r;
   assign last_nonce = (n == 8'(NUM_NONCES - 1));
   assign wr_sum     = 32'(base) + 32'(n) + 32'(t[2:0]) * 32'(WORD_STRIDE);

   // st[0..7] hold a..h during the rounds and H0..H7 after FINAL
   always_comb begin
      big_s1 = rotr(st[4], 6) ^ rotr(st[4], 11) ^ rotr(st[4], 25);
      ch     = (st[4] & st[5]) ^ (~st[4] & st[6]);
      t1     = st[7] + big_s1 + ch + K[t] + w[0];
      big_s0 = rotr(st[0], 2) ^ rotr(st[0], 13) ^ rotr(st[0], 22);
      maj    = (st[0] & st[1]) ^ (st[0] & st[2]) ^ (st[1] & st[2]);
      t2     = big_s0 + maj;
      w_new  = (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9]
             + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];
   end

   always_comb begin
      state_nxt      = state;
      mem_we         = 1'b0;
      mem_addr       = 16'h0000;
      mem_write_data = 32'h0000_0000;
      case (state)
         IDLE:    if (start) state_nxt = LOAD;
         LOAD:    state_nxt = COMPUTE;
         COMPUTE: if (t == 6'd63) state_nxt = FINAL;
         FINAL:   state_nxt = WRITE;
         WRITE: begin
            mem_we         = 1'b1;
            mem_addr       = wr_sum[15:0];
            mem_write_data = st[t[2:0]];
            if (t[2:0] == 3'd7) state_nxt = last_nonce ? IDLE : LOAD;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         n      <= '0;
         t      <= '0;
         base   <= '0;
         done_r <= 1'b0;
         for (int i = 0; i < 8; i++)  st[i] <= '0;
         for (int i = 0; i < 16; i++) w[i]  <= '0;
      end else begin
         state  <= state_nxt;
         done_r <= (state == WRITE) && (t[2:0] == 3'd7) && last_nonce;
         case (state)
            IDLE: begin
               if (start) begin
                  base <= output_addr;
                  n    <= '0;
               end
            end
            LOAD: begin
               for (int j = 0; j < 8; j++) begin
                  st[j] <= IV[j];
                  w[j]  <= hin[int'(n)*256 + j*32 +: 32];
               end
               w[8] <= 32'h8000_0000;
               for (int j = 9; j < 15; j++) w[j] <= '0;
               w[15] <= 32'h0000_0100;
               t <= '0;
            end
            COMPUTE: begin
               st[7] <= st[6];
               st[6] <= st[5];
               st[5] <= st[4];
               st[4] <= st[3] + t1;
               st[3] <= st[2];
               st[2] <= st[1];
               st[1] <= st[0];
               st[0] <= t1 + t2;
               for (int i = 0; i < 15; i++) w[i] <= w[i+1];
               w[15] <= w_new;
               t <= t + 6'd1;
            end
            FINAL: begin
               for (int j = 0; j < 8; j++) st[j] <= IV[j] + st[j];
               t <= '0;
            end
            WRITE: begin
               if (t[2:0] == 3'd7) begin
                  t <= '0;
                  if (!last_nonce) n <= n + 8'd1;
               end else begin
                  t <= t + 6'd1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef SHA256_BATCH_CYCLE_CNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cycle_count <= '0;
      else if (state == IDLE && start)
         cycle_count <= '0;
      else if (busy)
         cycle_count <= cycle_count + 32'd1;
   end
`endif

endmodule

// File: tb/tb_sha256_batch_hasher.sv
module tb_sha256_batch_hasher;

   localparam logic [31:0] IV_T [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   localparam logic [31:0] K_T [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   localparam logic [31:0] ZERO_DIGEST [8] = '{
      32'h66687aad, 32'hf862bd77, 32'h6c8fc18b, 32'h8e9f8e20,
      32'h08971485, 32'h6ee233b3, 32'h902a591d, 32'h0d5f2925};

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   // instance a: 1 nonce, stride 1
   logic start_a = 0, busy_a, done_a, mclk_a, we_a;
   logic [15:0] oaddr_a = 0, addr_a;
   logic [31:0] wdata_a;
   logic [255:0] hin_a = '0;
   // instance b: defaults (16 nonces, stride 16)
   logic start_b = 0, busy_b, done_b, mclk_b, we_b;
   logic [15:0] oaddr_b = 0, addr_b;
   logic [31:0] wdata_b;
   logic [16*256-1:0] hin_b = '0;
   // instance c: 2 nonces, stride 4
   logic start_c = 0, busy_c, done_c, mclk_c, we_c;
   logic [15:0] oaddr_c = 0, addr_c;
   logic [31:0] wdata_c;
   logic [511:0] hin_c = '0;
`ifdef SHA256_BATCH_CYCLE_CNT_EN
   logic [31:0] cc_a, cc_b, cc_c;
`endif

   sha256_batch_hasher #(.NUM_NONCES(1), .WORD_STRIDE(1)) u_a (
      .clk(clk), .reset_n(reset_n), .start(start_a), .output_addr(oaddr_a), .hin(hin_a),
      .busy(busy_a), .done(done_a), .mem_clk(mclk_a), .mem_we(we_a), .mem_addr(addr_a),
      .mem_write_data(wdata_a)
`ifdef SHA256_BATCH_CYCLE_CNT_EN
      , .cycle_count(cc_a)
`endif
   );

   sha256_batch_hasher u_b (
      .clk(clk), .reset_n(reset_n), .start(start_b), .output_addr(oaddr_b), .hin(hin_b),
      .busy(busy_b), .done(done_b), .mem_clk(mclk_b), .mem_we(we_b), .mem_addr(addr_b),
      .mem_write_data(wdata_b)
`ifdef SHA256_BATCH_CYCLE_CNT_EN
      , .cycle_count(cc_b)
`endif
   );

   sha256_batch_hasher #(.NUM_NONCES(2), .WORD_STRIDE(4)) u_c (
      .clk(clk), .reset_n(reset_n), .start(start_c), .output_addr(oaddr_c), .hin(hin_c),
      .busy(busy_c), .done(done_c), .mem_clk(mclk_c), .mem_we(we_c), .mem_addr(addr_c),
      .mem_write_data(wdata_c)
`ifdef SHA256_BATCH_CYCLE_CNT_EN
      , .cycle_count(cc_c)
`endif
   );

   // write / done logs, absolute cycle numbers
   logic [15:0] wa_a[$], wa_b[$], wa_c[$];
   logic [31:0] wd_a[$], wd_b[$], wd_c[$];
   int wc_a[$], wc_b[$], wc_c[$];
   int dc_a[$], dc_b[$], dc_c[$];

   always @(negedge clk) begin
      if (we_a) begin wa_a.push_back(addr_a); wd_a.push_back(wdata_a); wc_a.push_back(cyc); end
      if (we_b) begin wa_b.push_back(addr_b); wd_b.push_back(wdata_b); wc_b.push_back(cyc); end
      if (we_c) begin wa_c.push_back(addr_c); wd_c.push_back(wdata_c); wc_c.push_back(cyc); end
      if (done_a) dc_a.push_back(cyc);
      if (done_b) dc_b.push_back(cyc);
      if (done_c) dc_c.push_back(cyc);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ror(input logic [31:0] x, input int r);
      return (x >> r) | (x << (32 - r));
   endfunction

   // plain SHA-256 of one padded block holding the 8-word digest
   function automatic logic [255:0] ref_hash(input logic [255:0] d);
      logic [31:0] w [64];
      logic [31:0] v [8];
      logic [31:0] t1, t2;
      logic [255:0] r;
      for (int i = 0; i < 8; i++) w[i] = d[i*32 +: 32];
      w[8] = 32'h8000_0000;
      for (int i = 9; i < 15; i++) w[i] = 32'h0;
      w[15] = 32'd256;
      for (int i = 16; i < 64; i++)
         w[i] = (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
              + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
      for (int i = 0; i < 8; i++) v[i] = IV_T[i];
      for (int i = 0; i < 64; i++) begin
         t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
            + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K_T[i] + w[i];
         t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
            + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
         v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
      end
      for (int j = 0; j < 8; j++) r[j*32 +: 32] = IV_T[j] + v[j];
      return r;
   endfunction

   task automatic verify_b(input string tag, input int t0, input logic [16*256-1:0] h);
      logic [255:0] dg;
      int i;
      check({tag, "_nwrites"}, 32'(wa_b.size()), 32'd128);
      if (wa_b.size() == 128) begin
         for (int n = 0; n < 16; n++) begin
            dg = ref_hash(h[n*256 +: 256]);
            for (int j = 0; j < 8; j++) begin
               i = n*8 + j;
               check($sformatf("%s_addr_n%0d_j%0d", tag, n, j), 32'(wa_b[i]), 32'(n + 16*j));
               check($sformatf("%s_data_n%0d_j%0d", tag, n, j), wd_b[i], dg[j*32 +: 32]);
               check($sformatf("%s_wcyc_n%0d_j%0d", tag, n, j), 32'(wc_b[i] - t0), 32'(n*74 + 67 + j));
            end
         end
      end
      check({tag, "_ndone"}, 32'(dc_b.size()), 32'd1);
      if (dc_b.size() >= 1) check({tag, "_done_cyc"}, 32'(dc_b[0] - t0), 32'd1185);
   endtask

   initial begin
      int t0, k;
      logic [255:0] dg;
      logic [16*256-1:0] hsave;

      // ---------------- reset state
      repeat (3) @(negedge clk);
      check("rst_busy", {31'b0, busy_b}, 32'd0);
      check("rst_done", {31'b0, done_b}, 32'd0);
      check("rst_we", {31'b0, we_b}, 32'd0);
      check("rst_addr", 32'(addr_b), 32'd0);
      check("rst_data", wdata_b, 32'd0);
      check("mem_clk_follows_clk", {31'b0, mclk_b}, {31'b0, clk});
`ifdef SHA256_BATCH_CYCLE_CNT_EN
      check("rst_cc", cc_b, 32'd0);
`endif
      reset_n = 1'b1;
      @(negedge clk);

      // ---------------- single nonce, zero digest, start held through done
      hin_a = '0;
      oaddr_a = 16'h0100;
      start_a = 1'b1;
      @(negedge clk);
      t0 = cyc - 1;
      check("a_busy_c1", {31'b0, busy_a}, 32'd1);
      k = 0;
      while (!done_a && k < 200) begin @(negedge clk); k++; end
      check("a_done_seen", {31'b0, done_a}, 32'd1);
      check("a_done_cyc", 32'(cyc - t0), 32'd75);
      check("a_busy_at_done", {31'b0, busy_a}, 32'd0);
`ifdef SHA256_BATCH_CYCLE_CNT_EN
      check("a_cc", cc_a, 32'd74);
`endif
      check("a_nwrites", 32'(wa_a.size()), 32'd8);
      if (wa_a.size() >= 8)
         for (int j = 0; j < 8; j++) begin
            check($sformatf("a_addr_j%0d", j), 32'(wa_a[j]), 32'h0100 + 32'(j));
            check($sformatf("a_data_j%0d", j), wd_a[j], ZERO_DIGEST[j]);
            check($sformatf("a_wcyc_j%0d", j), 32'(wc_a[j] - t0), 32'(67 + j));
         end
      @(negedge clk);
      check("a_restart_busy", {31'b0, busy_a}, 32'd1);
      start_a = 1'b0;
      k = 0;
      while (!done_a && k < 200) begin @(negedge clk); k++; end
      check("a_done2_cyc", 32'(cyc - t0), 32'd150);
      repeat (3) @(negedge clk);
      check("a_nwrites2", 32'(wa_a.size()), 32'd16);
      check("a_ndone", 32'(dc_a.size()), 32'd2);

      // ---------------- 16 nonces, random digests, stray start mid-batch
      for (int i = 0; i < 128; i++) hin_b[i*32 +: 32] = $urandom();
      oaddr_b = 16'h0000;
      start_b = 1'b1;
      @(negedge clk);
      t0 = cyc - 1;
      start_b = 1'b0;
      check("b_busy_c1", {31'b0, busy_b}, 32'd1);
      while (cyc - t0 < 500) @(negedge clk);
      oaddr_b = 16'h4000;
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      k = 0;
      while (!done_b && k < 1300) begin @(negedge clk); k++; end
      check("b_done_seen", {31'b0, done_b}, 32'd1);
`ifdef SHA256_BATCH_CYCLE_CNT_EN
      check("b_cc", cc_b, 32'd1184);
`endif
      repeat (4) @(negedge clk);
      verify_b("b", t0, hin_b);

      // ---------------- reset during WRITE of nonce 3
      wa_b.delete(); wd_b.delete(); wc_b.delete(); dc_b.delete();
      for (int i = 0; i < 128; i++) hin_b[i*32 +: 32] = $urandom();
      oaddr_b = 16'h0000;
      start_b = 1'b1;
      @(negedge clk);
      t0 = cyc - 1;
      start_b = 1'b0;
      while (cyc - t0 < 3*74 + 67 + 3) @(negedge clk);
      check("r_we_before", {31'b0, we_b}, 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("r_we_async", {31'b0, we_b}, 32'd0);
      check("r_busy_async", {31'b0, busy_b}, 32'd0);
      check("r_addr_async", 32'(addr_b), 32'd0);
      check("r_data_async", wdata_b, 32'd0);
      dc_b.delete();
      start_b = 1'b1;
      repeat (3) @(negedge clk);
      check("r_no_done", 32'(dc_b.size()), 32'd0);
      wa_b.delete(); wd_b.delete(); wc_b.delete(); dc_b.delete();
      hsave = hin_b;
      reset_n = 1'b1;
      @(negedge clk);
      t0 = cyc - 1;
      start_b = 1'b0;
      check("r_start_first_edge", {31'b0, busy_b}, 32'd1);
      k = 0;
      while (!done_b && k < 1300) begin @(negedge clk); k++; end
      check("r_done_seen", {31'b0, done_b}, 32'd1);
      repeat (4) @(negedge clk);
      verify_b("r", t0, hsave);

      // ---------------- address wrap, 2 nonces, stride 4
      for (int i = 0; i < 16; i++) hin_c[i*32 +: 32] = $urandom();
      oaddr_c = 16'hFFFC;
      start_c = 1'b1;
      @(negedge clk);
      t0 = cyc - 1;
      start_c = 1'b0;
      k = 0;
      while (!done_c && k < 300) begin @(negedge clk); k++; end
      check("c_done_seen", {31'b0, done_c}, 32'd1);
      check("c_done_cyc", 32'(cyc - t0), 32'd149);
`ifdef SHA256_BATCH_CYCLE_CNT_EN
      check("c_cc", cc_c, 32'd148);
      repeat (3) @(negedge clk);
      check("c_cc_hold", cc_c, 32'd148);
`else
      repeat (3) @(negedge clk);
`endif
      check("c_nwrites", 32'(wa_c.size()), 32'd16);
      check("c_ndone", 32'(dc_c.size()), 32'd1);
      if (wa_c.size() >= 16)
         for (int n = 0; n < 2; n++) begin
            dg = ref_hash(hin_c[n*256 +: 256]);
            for (int j = 0; j < 8; j++) begin
               check($sformatf("c_addr_n%0d_j%0d", n, j), 32'(wa_c[n*8+j]),
                     32'(16'(32'hFFFC + 32'(n) + 32'(4*j))));
               check($sformatf("c_data_n%0d_j%0d", n, j), wd_c[n*8+j], dg[j*32 +: 32]);
            end
         end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sha256_batch_hasher.md
# sha256_batch_hasher

Parametrised second-stage SHA-256 engine for the bitcoin_hash datapath. It takes NUM_NONCES first-stage 256-bit digests and hashes each one as a single padded 512-bit block, one nonce at a time. Each result is written to memory as a strided word array. It generalises the fixed 16-nonce hasher in three ways: configurable nonce count and stride, a rolling 16-word message schedule in place of a 64-word precompute, and a start/busy/done handshake.

## Interface
- NUM_NONCES, 16: number of digests per batch, 1..256.
- WORD_STRIDE, NUM_NONCES: address distance between word j and word j+1 of one nonce's digest; must be ≥ NUM_NONCES.
- clk  in  1  clock; mem_clk is driven from it.
- reset_n  in  1  reset, asynchronous, active-low.
- start  in  1  batch request, sampled in IDLE only.
- output_addr  in  16  base word address, sampled at start.
- hin  in  NUM_NONCES*256  input digests. Word j (0..7) of nonce n is hin[(n*256 + j*32) +: 32].
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the batch completes.
- mem_clk  out  1  = clk.
- mem_we  out  1  write strobe.
- mem_addr  out  16  write address.
- mem_write_data  out  32  write data.

## Operation
- States: IDLE, LOAD, COMPUTE, FINAL, WRITE. nonce counter n, round/word counter t.
- IDLE: if start, latch output_addr, set n=0 and busy=1, then go to LOAD. start is ignored in every other state.
- LOAD (1 cycle):
  - a..h ← SHA-256 IV.
  - W window[0..7] ← hin words of nonce n. window[8] = 0x80000000, window[9..14] = 0, window[15] = 0x00000100.
  - t ← 0.
- COMPUTE (64 cycles, t=0..63):
  - One round per cycle using window[0] and K[t].
  - Window shifts down by one. The new window[15] = σ1(w[14]) + w[9] + σ0(w[1]) + w[0], computed from the pre-shift window.
  - All arithmetic is mod 2^32.
- FINAL (1 cycle): H_j ← IV_j + {a..h}_j, for j = 0..7.
- WRITE (8 cycles, j=0..7):
  - mem_we=1, mem_write_data=H_j.
  - mem_addr = output_addr + n + j*WORD_STRIDE, truncated to 16 bits (wraps at 0xFFFF).
  - After j=7: if n < NUM_NONCES-1, increment n and go to LOAD. Otherwise go to IDLE, pulse done, clear busy.
- hin must stay stable while busy. Nonce n's words are sampled in its LOAD cycle.
- mem_we is 0 in every state other than WRITE.

## Timing
- Reset values: busy=0, done=0, mem_we=0, mem_addr=0, mem_write_data=0, state=IDLE, all counters 0.
- Start accepted on clock edge E0. LOAD occupies cycle 1.
- Each nonce takes 74 cycles: 1 LOAD + 64 COMPUTE + 1 FINAL + 8 WRITE.
- Nonce n's writes occur in cycles n*74+67 .. n*74+74.
- done is high in cycle NUM_NONCES*74+1; busy falls in that same cycle.
- A start held high through done begins a new batch at the next edge; no idle gap is required.
- Reset asserted mid-batch: outputs return to reset values immediately and asynchronously. The partial batch is abandoned and no done is issued.
- Reset released with start already high: start is accepted at the first clock edge after release.

## Configuration
- SHA256_BATCH_CYCLE_CNT_EN defined:
  - Adds output port cycle_count (32 bits, reset 0).
  - Cleared to 0 when start is accepted, then incremented each cycle while busy.
  - Holds its final value (NUM_NONCES*74) after done until the next start.
- SHA256_BATCH_CYCLE_CNT_EN undefined: the port and counter do not exist; all other behaviour is identical.

## Test plan
- NUM_NONCES=1, hin=0, output_addr=0x0100 -> 8 writes to 0x0100..0x0107 (stride 1) with data 66687aad, f862bd77, 6c8fc18b, 8e9f8e20, 08971485, 6ee233b3, 902a591d, 0d5f2925; done in cycle 75.
- Default parameters (16 nonces), random hin, output_addr=0 -> 128 writes. Nonce n word j lands at n+16j and matches the reference model. done pulses exactly once, at cycle 1185.
- start pulsed while busy, mid-batch -> ignored: no restart, and the write sequence and done timing are unchanged.
- reset_n dropped during WRITE of nonce 3 -> mem_we=0 and busy=0 immediately, no done. A new start afterwards completes a full, correct batch.
- output_addr=0xFFFC, NUM_NONCES=2, WORD_STRIDE=4 -> addresses wrap past 0xFFFF to 0x0000 onward. With SHA256_BATCH_CYCLE_CNT_EN defined, cycle_count=148 after done.
